mac_tx_frame_fifo: RTL and testbench

- Frame-aware byte FIFO between the USB bulk-OUT unpacker and the MAC transmitter.
- Accepts payload bytes tagged with end-of-frame.
- Tells the transmitter when at least one complete frame is stored.
- Presents that frame byte by byte through the transmitter's rd_en / fifo_empty handshake, showing "empty" at each frame boundary.
- Frames that would overflow storage are discarded whole, so the transmitter never sees a truncated frame.

---
 rtl/mac_tx_frame_fifo.sv | 145 ++++++++++++++
 tb/tb_mac_tx_frame_fifo.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_tx_frame_fifo.sv
// Frame-aware byte FIFO between the USB bulk-OUT unpacker and the MAC transmitter; only whole frames become readable.
// Latency: commit visible the cycle after wr_last; backpressure via wr_full, overflowing frames are dropped whole.
module mac_tx_frame_fifo #(
  parameter int DEPTH      = 2048,
  parameter int MAX_FRAMES = 8,
  localparam int AW  = $clog2(DEPTH),
  localparam int PW  = AW + 1,
  localparam int FCW = $clog2(MAX_FRAMES + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           wr_en,
  input  logic [7:0]     wr_data,
  input  logic           wr_last,
  output logic           wr_full,
  output logic           wr_drop,
  input  logic           rd_en,
  output logic [0:7]     rd_data,
  output logic           fifo_empty,
  output logic           data_ready,
  output logic [FCW-1:0] frame_count
);

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } entry_t;

  typedef enum logic {
    ACCEPT  = 1'b0,
    DISCARD = 1'b1
  } wr_state_t;

  localparam logic [PW-1:0]  DEPTH_P = PW'(DEPTH);
  localparam logic [FCW-1:0] MAX_P   = FCW'(MAX_FRAMES);

  entry_t mem [DEPTH];

  wr_state_t      state, state_n;
  logic [PW-1:0]  wr_ptr, wr_ptr_n;
  logic [PW-1:0]  wr_commit, wr_commit_n;
  logic [PW-1:0]  rd_ptr, rd_ptr_n;
  logic [PW-1:0]  occupancy;
  logic [FCW-1:0] frame_count_n;
  logic           eof_hold, eof_hold_n;
  logic           rd_last;
  logic           pop, last_pop;
  logic           accept_wr, overflow, store, commit;
  logic [AW-1:0]  rd_addr;
  entry_t         wr_entry, head_n;

  assign occupancy = wr_ptr - rd_ptr;
  assign wr_entry  = '{last: wr_last, data: wr_data};

  assign pop      = rd_en & ~fifo_empty;
  assign last_pop = pop & rd_last;

  // Overflow is judged on registered occupancy and frame count only.
  assign accept_wr = (state == ACCEPT) & wr_en;
  assign overflow  = accept_wr & ((occupancy == DEPTH_P) | (wr_last & (frame_count == MAX_P)));
  assign store     = accept_wr & ~overflow;
  assign commit    = store & wr_last;

  always_comb begin
    wr_ptr_n      = wr_ptr;
    wr_commit_n   = wr_commit;
    rd_ptr_n      = rd_ptr;
    state_n       = state;
    frame_count_n = frame_count;
    eof_hold_n    = eof_hold;

    if (overflow)
      wr_ptr_n = wr_commit;
    else if (store)
      wr_ptr_n = wr_ptr + PW'(1);

    if (commit)
      wr_commit_n = wr_ptr + PW'(1);

    if (pop)
      rd_ptr_n = rd_ptr + PW'(1);

    case (state)
      ACCEPT:  if (overflow && !wr_last) state_n = DISCARD;
      DISCARD: if (wr_en && wr_last)     state_n = ACCEPT;
      default: state_n = ACCEPT;
    endcase

    case ({commit, last_pop})
      2'b10:   frame_count_n = frame_count + FCW'(1);
      2'b01:   frame_count_n = frame_count - FCW'(1);
      default: frame_count_n = frame_count;
    endcase

    if (last_pop)
      eof_hold_n = 1'b1;
    else if (!rd_en)
      eof_hold_n = 1'b0;
  end

  // Prefetch the head at the next read pointer; bypass a byte landing there this cycle.
  assign rd_addr = rd_ptr_n[AW-1:0];

  always_comb begin
    head_n = mem[rd_addr];
    if (store && (wr_ptr[AW-1:0] == rd_addr))
      head_n = wr_entry;
  end

  always_ff @(posedge clk) begin
    if (store)
      mem[wr_ptr[AW-1:0]] <= wr_entry;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ACCEPT;
      wr_ptr      <= '0;
      wr_commit   <= '0;
      rd_ptr      <= '0;
      frame_count <= '0;
      eof_hold    <= 1'b0;
      wr_full     <= 1'b0;
      wr_drop     <= 1'b0;
      fifo_empty  <= 1'b1;
      data_ready  <= 1'b0;
      rd_data     <= '0;
      rd_last     <= 1'b0;
    end else begin
      state       <= state_n;
      wr_ptr      <= wr_ptr_n;
      wr_commit   <= wr_commit_n;
      rd_ptr      <= rd_ptr_n;
      frame_count <= frame_count_n;
      eof_hold    <= eof_hold_n;
      wr_full     <= ((wr_ptr_n - rd_ptr_n) == DEPTH_P) | (frame_count_n == MAX_P);
      wr_drop     <= overflow;
      fifo_empty  <= (wr_commit_n == rd_ptr_n) | eof_hold_n;
      data_ready  <= (frame_count_n != '0);
      rd_data     <= head_n.data;
      rd_last     <= head_n.last;
    end
  end

endmodule

// File: tb/tb_mac_tx_frame_fifo.sv
// Directed bench for mac_tx_frame_fifo: full-size and 64-entry instances share stimulus; a monitor checks popped bytes.
module tb_mac_tx_frame_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_last = 1'b0;
  logic       rd_en = 1'b0;
  logic       sel = 1'b0;

  logic       b_wr_full, b_wr_drop, b_fifo_empty, b_data_ready;
  logic [0:7] b_rd_data;
  logic [3:0] b_frame_count;
  logic       s_wr_full, s_wr_drop, s_fifo_empty, s_data_ready;
  logic [0:7] s_rd_data;
  logic [3:0] s_frame_count;

  logic       m_full, m_drop, m_fe, m_dr;
  logic [7:0] m_rd_data;
  logic [3:0] m_fc;

  logic [7:0] exp_q [$];
  int tests_run = 0;
  int tests_failed = 0;
  int drop_cnt = 0;

  always #5 clk = ~clk;

  mac_tx_frame_fifo #(.DEPTH(2048), .MAX_FRAMES(8)) dut_big (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .wr_last(wr_last),
    .wr_full(b_wr_full), .wr_drop(b_wr_drop), .rd_en(rd_en), .rd_data(b_rd_data),
    .fifo_empty(b_fifo_empty), .data_ready(b_data_ready), .frame_count(b_frame_count)
  );

  mac_tx_frame_fifo #(.DEPTH(64), .MAX_FRAMES(8)) dut_small (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .wr_last(wr_last),
    .wr_full(s_wr_full), .wr_drop(s_wr_drop), .rd_en(rd_en), .rd_data(s_rd_data),
    .fifo_empty(s_fifo_empty), .data_ready(s_data_ready), .frame_count(s_frame_count)
  );

  always_comb begin
    m_full    = sel ? s_wr_full     : b_wr_full;
    m_drop    = sel ? s_wr_drop     : b_wr_drop;
    m_fe      = sel ? s_fifo_empty  : b_fifo_empty;
    m_dr      = sel ? s_data_ready  : b_data_ready;
    m_rd_data = sel ? s_rd_data     : b_rd_data;
    m_fc      = sel ? s_frame_count : b_frame_count;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted pop must match the oldest expected byte.
  always @(negedge clk) begin
    if (!reset) begin
      if (m_drop) drop_cnt++;
      if (rd_en && !m_fe) begin
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL unexpected_pop: got %02h, expected no byte", m_rd_data);
        end else begin
          check("rd_data", 32'(m_rd_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wr_en = 1'b0;
    wr_last = 1'b0;
    rd_en = 1'b0;
    exp_q.delete();
    tick();
    tick();
    reset = 1'b0;
    drop_cnt = 0;
  endtask

  task automatic write_frame(input logic [7:0] base, input int len, input bit with_last, input bit push);
    for (int i = 0; i < len; i++) begin
      wr_en   = 1'b1;
      wr_data = base + 8'(i);
      wr_last = with_last && (i == len - 1);
      if (push) exp_q.push_back(wr_data);
      tick();
    end
    wr_en   = 1'b0;
    wr_last = 1'b0;
  endtask

  task automatic read_until(input int remaining, input int budget);
    int n = 0;
    rd_en = 1'b1;
    while (exp_q.size() > remaining && n < budget) begin
      tick();
      n++;
    end
    check("read_until_budget", 32'(exp_q.size() > remaining), 32'd0);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    rd_en = 1'b1;
    while (exp_q.size() > 0 && n < budget) begin
      tick();
      n++;
      if (m_fe && exp_q.size() > 0) begin
        rd_en = 1'b0;
        tick();
        rd_en = 1'b1;
        n++;
      end
    end
    rd_en = 1'b0;
    check("drain_done", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset state
    sel = 1'b0;
    do_reset();
    check("rst_wr_full", 32'(m_full), 32'd0);
    check("rst_wr_drop", 32'(m_drop), 32'd0);
    check("rst_fifo_empty", 32'(m_fe), 32'd1);
    check("rst_data_ready", 32'(m_dr), 32'd0);
    check("rst_frame_count", 32'(m_fc), 32'd0);
    check("rst_rd_data", 32'(m_rd_data), 32'd0);

    // Single 60-byte frame
    write_frame(8'h00, 60, 1'b1, 1'b1);
    check("t1_data_ready", 32'(m_dr), 32'd1);
    check("t1_frame_count", 32'(m_fc), 32'd1);
    check("t1_fifo_empty", 32'(m_fe), 32'd0);
    read_until(0, 100);
    check("t1_empty_after", 32'(m_fe), 32'd1);
    check("t1_fc_after", 32'(m_fc), 32'd0);
    check("t1_dr_after", 32'(m_dr), 32'd0);
    rd_en = 1'b0;
    tick();

    // Two back-to-back frames, eof_hold at the boundary
    do_reset();
    write_frame(8'hA0, 46, 1'b1, 1'b1);
    write_frame(8'hB0, 46, 1'b1, 1'b1);
    check("t2_frame_count", 32'(m_fc), 32'd2);
    read_until(46, 100);
    check("t2_hold_empty", 32'(m_fe), 32'd1);
    check("t2_hold_dr", 32'(m_dr), 32'd1);
    check("t2_hold_fc", 32'(m_fc), 32'd1);
    tick();
    check("t2_hold_stays", 32'(m_fe), 32'd1);
    rd_en = 1'b0;
    tick();
    check("t2_hold_cleared", 32'(m_fe), 32'd0);
    check("t2_head_b", 32'(m_rd_data), 32'h0B0);
    read_until(1, 100);
    check("t2_dr_before_last", 32'(m_dr), 32'd1);
    read_until(0, 10);
    check("t2_dr_after", 32'(m_dr), 32'd0);
    check("t2_fc_after", 32'(m_fc), 32'd0);
    check("t2_empty_after", 32'(m_fe), 32'd1);
    rd_en = 1'b0;
    tick();

    // Uncommitted bytes are not readable
    do_reset();
    write_frame(8'h40, 30, 1'b0, 1'b1);
    check("t3_data_ready", 32'(m_dr), 32'd0);
    check("t3_fifo_empty", 32'(m_fe), 32'd1);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("t3_rd_ptr", 32'(dut_big.rd_ptr), 32'd0);
    write_frame(8'h5E, 1, 1'b1, 1'b1);
    check("t3_fc_commit", 32'(m_fc), 32'd1);
    drain(200);

    // Storage overflow on the 64-entry instance
    sel = 1'b1;
    do_reset();
    write_frame(8'h10, 40, 1'b1, 1'b1);
    write_frame(8'h80, 30, 1'b1, 1'b0);
    tick();
    check("t4_drop_cnt", 32'(drop_cnt), 32'd1);
    check("t4_frame_count", 32'(m_fc), 32'd1);
    check("t4_wr_full", 32'(m_full), 32'd0);
    check("t4_wr_ptr", 32'(dut_small.wr_ptr), 32'd40);
    drain(200);
    check("t4_empty_after", 32'(m_fe), 32'd1);
    check("t4_fc_after", 32'(m_fc), 32'd0);
    sel = 1'b0;

    // Frame counter limit
    do_reset();
    for (int f = 0; f < 8; f++)
      write_frame(8'hC0 + 8'(4 * f), 4, 1'b1, 1'b1);
    check("t5_fc_8", 32'(m_fc), 32'd8);
    check("t5_full_8", 32'(m_full), 32'd1);
    write_frame(8'hF0, 4, 1'b1, 1'b0);
    tick();
    check("t5_drop_cnt", 32'(drop_cnt), 32'd1);
    check("t5_fc_still_8", 32'(m_fc), 32'd8);
    read_until(28, 50);
    check("t5_fc_7", 32'(m_fc), 32'd7);
    check("t5_full_clear", 32'(m_full), 32'd0);
    rd_en = 1'b0;
    tick();
    write_frame(8'h70, 4, 1'b1, 1'b1);
    check("t5_fc_refill", 32'(m_fc), 32'd8);
    check("t5_full_refill", 32'(m_full), 32'd1);
    drain(300);
    check("t5_fc_after", 32'(m_fc), 32'd0);

    // Reset in the middle of a read
    do_reset();
    write_frame(8'h30, 20, 1'b1, 1'b1);
    write_frame(8'h90, 20, 1'b1, 1'b1);
    read_until(30, 100);
    rd_en = 1'b0;
    reset = 1'b1;
    exp_q.delete();
    tick();
    reset = 1'b0;
    check("t6_fc", 32'(m_fc), 32'd0);
    check("t6_empty", 32'(m_fe), 32'd1);
    check("t6_dr", 32'(m_dr), 32'd0);
    check("t6_rd_data", 32'(m_rd_data), 32'd0);
    write_frame(8'h60, 12, 1'b1, 1'b1);
    check("t6_rd_ptr", 32'(dut_big.rd_ptr), 32'd0);
    check("t6_fc_new", 32'(m_fc), 32'd1);
    check("t6_head", 32'(m_rd_data), 32'h060);
    drain(100);
    check("t6_empty_after", 32'(m_fe), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
